// File: rtl/ram_4k.sv
// 4096 x 16 single-port RAM: synchronous write, combinational read, and a post-reset
// clear sweep (busy high). Optional per-word even parity under RAM4K_PARITY_EN.
module ram_4k #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              parity_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              clear_we;

  logic [DATA_W-1:0] mem [DEPTH];

  // State register: reset restarts the sweep from word 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {ADDR_W{1'b1}})
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_reg == CLEAR);
    clear_we = (state_reg == CLEAR);
  end

  // The sweep owns the write port while busy, so user writes are dropped
  always_ff @(posedge clk) begin
    if (clear_we)
      mem[cnt_reg] <= '0;
    else if (write_enable)
      mem[address] <= data_in;
  end

  assign data_out = busy ? '0 : mem[address];

`ifdef RAM4K_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear_we)
      par_mem[cnt_reg] <= 1'b0;
    else if (write_enable)
      par_mem[address] <= ^data_in;
  end

  assign parity_err = busy ? 1'b0 : ((^mem[address]) != par_mem[address]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_4k.sv
// Directed self-checking bench for ram_4k: clear sweep timing, writes/reads,
// write-first behaviour, boundary addresses and mid-sweep reset restart.
module tb_ram_4k;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic [15:0] data_in;
  logic        write_enable;
  logic [15:0] data_out;
  logic        busy;
  logic        parity_err;

  int vectors = 0;
  int miscompares = 0;

  ram_4k dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .data_in      (data_in),
    .write_enable (write_enable),
    .data_out     (data_out),
    .busy         (busy),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [11:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check(tag, {16'h0, data_out}, {16'h0, exp});
    check({tag, "_par"}, {31'h0, parity_err}, 32'h0);
    $display("read  %s addr=%0d data_out=%0d", tag, a, data_out);
  endtask

  // Counts rising edges from release until busy falls; optional dropped write at edge 10
  task automatic count_sweep(input string tag, input bit poke, output int edges);
    edges = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (!busy) break;
      if (poke && edges == 10) begin
        address = 12'd5; data_in = 16'd42; write_enable = 1'b1;
      end
      if (poke && edges == 11) write_enable = 1'b0;
      if (edges == 100) begin
        check({tag, "_busy_mid"}, {31'h0, busy}, 32'h1);
        check({tag, "_dout_mid"}, {16'h0, data_out}, 32'h0);
      end
    end
    check({tag, "_edges"}, edges, 32'd4096);
    $display("sweep %s finished after %0d edges", tag, edges);
  endtask

  initial begin
    int edges;
    int nonzero;
    logic [15:0] wvals [4];
    wvals[0] = 16'd1234; wvals[1] = 16'd5678; wvals[2] = 16'd9012; wvals[3] = 16'd3456;

    rst = 1'b0; address = 12'd3; data_in = 16'h0; write_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_dout", {16'h0, data_out}, 32'h0);
    check("rst_par", {31'h0, parity_err}, 32'h0);
    $display("reset busy=%0d data_out=%0d", busy, data_out);

    // Full sweep with a write attempt at address 5 while busy
    rst = 1'b1;
    count_sweep("sweep1", 1'b1, edges);
    write_enable = 1'b0;
    @(negedge clk);
    read_check("dropped_w5", 12'd5, 16'd0);
    nonzero = 0;
    for (int a = 0; a < 4096; a++) begin
      address = a[11:0];
      #1;
      if (data_out !== 16'd0) nonzero++;
    end
    check("clear_all_nonzero", nonzero, 32'd0);
    $display("scan all addresses: %0d nonzero words", nonzero);

    // Sequential writes with write-first observation around each edge
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = i[11:0]; data_in = wvals[i]; write_enable = 1'b1;
      #1;
      check("wr_before_edge", {16'h0, data_out}, 32'h0);
      @(posedge clk);
      #1;
      check("wr_after_edge", {16'h0, data_out}, {16'h0, wvals[i]});
      $display("write addr=%0d data=%0d readback=%0d", i, wvals[i], data_out);
    end
    @(negedge clk);
    write_enable = 1'b0;
    for (int i = 0; i < 4; i++) read_check("rd_seq", i[11:0], wvals[i]);

    // Changing data_in with write disabled must not touch memory
    @(negedge clk);
    address = 12'd2;
    #1 data_in = 16'd777;
    #1 check("no_we_comb", {16'h0, data_out}, 32'd9012);
    @(posedge clk);
    #1 check("no_we_edge", {16'h0, data_out}, 32'd9012);
    $display("no-write addr=2 data_in=777 data_out=%0d", data_out);

    // Boundary addresses
    @(negedge clk);
    address = 12'd4095; data_in = 16'hFFFF; write_enable = 1'b1;
    @(negedge clk);
    address = 12'd0; data_in = 16'h0001;
    @(negedge clk);
    write_enable = 1'b0;
    read_check("bnd_4095", 12'd4095, 16'hFFFF);
    read_check("bnd_0", 12'd0, 16'h0001);
    read_check("bnd_1", 12'd1, 16'd5678);

    // Reset lands mid-write: the write is lost and the sweep clears everything
    @(negedge clk);
    address = 12'd1; data_in = 16'hABCD; write_enable = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midwr_busy", {31'h0, busy}, 32'h1);
    check("midwr_dout", {16'h0, data_out}, 32'h0);
    write_enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2000; i++) @(posedge clk);
    #1 check("pre_restart_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("restart_busy", {31'h0, busy}, 32'h1);
    check("restart_dout", {16'h0, data_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    count_sweep("sweep2", 1'b0, edges);
    @(negedge clk);
    read_check("post_clr_0", 12'd0, 16'd0);
    read_check("post_clr_1", 12'd1, 16'd0);
    read_check("post_clr_3", 12'd3, 16'd0);
    read_check("post_clr_4095", 12'd4095, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
